// File: rtl/fifo_drain_pkg.sv
// ============================================================================
// Module   : fifo_drain_pkg
// Desc     : Shared types and constants for the FIFO read-side drain controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_drain_pkg;

    localparam logic [1:0] SKID_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } drain_occ_e;

endpackage

`default_nettype wire

// File: rtl/fifo_drain_skid.sv
// ============================================================================
// Module   : fifo_drain_skid
// Desc     : Two-entry in-order skid buffer (head/tail) with occupancy state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_drain_skid
    import fifo_drain_pkg::*;
#(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [FIFO_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [FIFO_WIDTH-1:0] head_data,
    output drain_occ_e            occ
);

    drain_occ_e            r_occ;
    drain_occ_e            w_occ_nxt;
    logic                  r_valid;
    logic [FIFO_WIDTH-1:0] r_head;
    logic [FIFO_WIDTH-1:0] r_tail;
    logic [FIFO_WIDTH-1:0] w_head_nxt;
    logic [FIFO_WIDTH-1:0] w_tail_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ   <= OCC0;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != OCC0);
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // A simultaneous push and pop keeps occupancy: the head advances and the
    // arriving word takes the slot behind it.
    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        case (r_occ)
            OCC0: begin
                if (push) begin
                    w_occ_nxt  = OCC1;
                    w_head_nxt = push_data;
                end
            end
            OCC1: begin
                if (push && pop) begin
                    w_head_nxt = push_data;
                end else if (push) begin
                    w_occ_nxt  = OCC2;
                    w_tail_nxt = push_data;
                end else if (pop) begin
                    w_occ_nxt  = OCC0;
                end
            end
            OCC2: begin
                if (pop) begin
                    w_head_nxt = r_tail;
                    if (push) begin
                        w_tail_nxt = push_data;
                    end else begin
                        w_occ_nxt  = OCC1;
                    end
                end
            end
            default: begin
                w_occ_nxt = OCC0;
            end
        endcase
    end

    assign valid     = r_valid;
    assign head_data = r_head;
    assign occ       = r_occ;

endmodule

`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
// ============================================================================
// Module   : fifo_drain_ctrl
// Desc     : Pops a synchronous FIFO into a valid/ready stream via a skid buffer.
//            Define FIFO_DRAIN_CNT_EN to add the 16-bit pop_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [15:0]           pop_count
`endif
);

    logic       r_inflight;
    logic       w_pop;
    drain_occ_e w_occ;
    logic [1:0] w_occ_bits;
    logic [1:0] w_level;

    assign w_pop      = m_valid && m_ready;
    assign w_occ_bits = w_occ;

    // Words held or in flight after this edge; a read is only issued when its
    // result is guaranteed a free slot.
    assign w_level    = w_occ_bits + {1'b0, r_inflight} - {1'b0, w_pop};
    assign fifo_rd_en = rst_n && !fifo_empty && (w_level < SKID_DEPTH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
        end
    end

    fifo_drain_skid #(
        .FIFO_WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data (fifo_dout),
        .pop       (w_pop),
        .valid     (m_valid),
        .head_data (m_data),
        .occ       (w_occ)
    );

`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] r_pop_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pop_count <= 16'd0;
        end else if (w_pop) begin
            r_pop_count <= r_pop_count + 16'd1;
        end
    end

    assign pop_count = r_pop_count;
`endif

endmodule

`default_nettype wire
